// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes,
// sequencer states and the instruction-width derivation.
package cu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_LT   = 4'hA;
    localparam logic [3:0] OP_EQ   = 4'hB;
    localparam logic [3:0] OP_MVI  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_JZ   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU codes are the ALU opcodes shifted down by one; zero means idle.
    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_AND  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_NOT  = 4'h6;
    localparam logic [3:0] ALU_SHL  = 4'h7;
    localparam logic [3:0] ALU_SHR  = 4'h8;
    localparam logic [3:0] ALU_LT   = 4'h9;
    localparam logic [3:0] ALU_EQ   = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        RD_A,
        RD_B,
        EXEC,
        WB,
        HALT
    } state_t;

    function automatic int instr_width(input int addr_w);
        return 4 + 2 * addr_w;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier for the multi-cycle control unit.
module cu_decode
    import cu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_mov,
    output logic       is_mvi,
    output logic       is_jmp,
    output logic       is_jz,
    output logic       is_halt,
    output logic [3:0] alu_op
);

    always_comb begin
        is_alu  = (opcode >= OP_ADD) && (opcode <= OP_EQ);
        is_mov  = (opcode == OP_MOV);
        is_mvi  = (opcode == OP_MVI);
        is_jmp  = (opcode == OP_JMP);
        is_jz   = (opcode == OP_JZ);
        is_halt = (opcode == OP_HALT);
        alu_op  = is_alu ? (opcode - 4'd1) : ALU_NONE;
    end

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: fetches from the program ROM and sequences the
// register file and ALU one port access per cycle, with jumps and halt.
module cu_multicycle
    import cu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int PC_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    output logic                          rom_read,
    output logic [PC_W-1:0]               rom_addr,
    input  logic [instr_width(ADDR_W)-1:0] rom_data,
    output logic                          ram_read,
    output logic                          ram_write,
    output logic [ADDR_W-1:0]             ram_read_addr,
    output logic [ADDR_W-1:0]             ram_write_addr,
    output logic [DATA_W-1:0]             ram_data_in,
    input  logic [DATA_W-1:0]             ram_data_out,
    output logic [3:0]                    alu_op,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    input  logic [DATA_W-1:0]             alu_result,
    input  logic                          alu_zero,
    output logic [PC_W-1:0]               pc,
    output logic                          zero_flag,
    output logic                          halted
);

    localparam int INSTR_W = instr_width(ADDR_W);

    state_t              state;
    state_t              state_nxt;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   res;

    logic [INSTR_W-1:0]  cur_instr;
    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   dest;
    logic [ADDR_W-1:0]   src;
    logic [PC_W-1:0]     target;
    logic [PC_W-1:0]     pc_inc;
    logic [DATA_W-1:0]   mvi_data;

    logic                is_alu;
    logic                is_mov;
    logic                is_mvi;
    logic                is_jmp;
    logic                is_jz;
    logic                is_halt;
    logic [3:0]          dec_alu_op;

    // In DECODE the instruction is still on the ROM bus; afterwards it lives in ir.
    assign cur_instr = (state == DECODE) ? rom_data : ir;
    assign opcode    = cur_instr[INSTR_W-1 -: 4];
    assign dest      = cur_instr[2*ADDR_W-1 -: ADDR_W];
    assign src       = cur_instr[ADDR_W-1:0];
    assign target    = PC_W'(cur_instr[2*ADDR_W-1:0]);
    assign pc_inc    = pc + PC_W'(1);
    assign mvi_data  = DATA_W'(src);

    assign rom_addr = pc;
    assign halted   = (state == HALT);

    cu_decode u_decode (
        .opcode  (opcode),
        .is_alu  (is_alu),
        .is_mov  (is_mov),
        .is_mvi  (is_mvi),
        .is_jmp  (is_jmp),
        .is_jz   (is_jz),
        .is_halt (is_halt),
        .alu_op  (dec_alu_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        rom_read       = 1'b0;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        ram_read_addr  = '0;
        ram_write_addr = '0;
        ram_data_in    = '0;
        alu_op         = ALU_NONE;
        alu_a          = '0;
        alu_b          = '0;
        case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                rom_read  = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                if (is_alu)       state_nxt = RD_A;
                else if (is_mov)  state_nxt = RD_B;
                else if (is_mvi)  state_nxt = WB;
                else if (is_halt) state_nxt = HALT;
                else              state_nxt = EXEC;
            end
            RD_A: begin
                ram_read      = 1'b1;
                ram_read_addr = dest;
                state_nxt     = RD_B;
            end
            RD_B: begin
                ram_read      = 1'b1;
                ram_read_addr = src;
                state_nxt     = EXEC;
            end
            EXEC: begin
                // Source value arrives from the RD_B read in this cycle.
                if (is_alu) begin
                    alu_op = dec_alu_op;
                    alu_a  = opa;
                    alu_b  = ram_data_out;
                end
                if (is_alu || is_mov) state_nxt = WB;
                else                  state_nxt = run ? FETCH : IDLE;
            end
            WB: begin
                ram_write      = 1'b1;
                ram_write_addr = dest;
                ram_data_in    = is_mvi ? mvi_data : res;
                state_nxt      = run ? FETCH : IDLE;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            zero_flag <= 1'b0;
            ir        <= '0;
            opa       <= '0;
            res       <= '0;
        end else begin
            case (state)
                DECODE: ir <= rom_data;
                RD_B: begin
                    if (is_alu) opa <= ram_data_out;
                end
                EXEC: begin
                    if (is_alu) begin
                        res       <= alu_result;
                        zero_flag <= alu_zero;
                    end else if (is_mov) begin
                        res <= ram_data_out;
                    end else if (is_jmp) begin
                        pc <= target;
                    end else if (is_jz) begin
                        pc <= zero_flag ? target : pc_inc;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                WB: pc <= pc_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_multicycle.sv
// Self-checking bench for cu_multicycle with behavioural ROM, register file and ALU.
module tb_cu_multicycle;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int PC_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               run;
    logic               rom_read;
    logic [PC_W-1:0]    rom_addr;
    logic [15:0]        rom_data = '0;
    logic               ram_read;
    logic               ram_write;
    logic [ADDR_W-1:0]  ram_read_addr;
    logic [ADDR_W-1:0]  ram_write_addr;
    logic [DATA_W-1:0]  ram_data_in;
    logic [DATA_W-1:0]  ram_data_out = '0;
    logic [3:0]         alu_op;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_zero;
    logic [PC_W-1:0]    pc;
    logic               zero_flag;
    logic               halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rom_mem [256];
    logic [15:0] ram_mem [64];

    always #5 clk = ~clk;

    cu_multicycle #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PC_W   (PC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .rom_read       (rom_read),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .ram_read       (ram_read),
        .ram_write      (ram_write),
        .ram_read_addr  (ram_read_addr),
        .ram_write_addr (ram_write_addr),
        .ram_data_in    (ram_data_in),
        .ram_data_out   (ram_data_out),
        .alu_op         (alu_op),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .pc             (pc),
        .zero_flag      (zero_flag),
        .halted         (halted)
    );

    always @(posedge clk) begin
        if (rom_read) rom_data <= rom_mem[rom_addr];
    end

    always @(posedge clk) begin
        if (ram_read)  ram_data_out <= ram_mem[ram_read_addr];
        if (ram_write) ram_mem[ram_write_addr] <= ram_data_in;
    end

    always_comb begin
        case (alu_op)
            4'h1:    alu_result = alu_a + alu_b;
            4'h2:    alu_result = alu_a - alu_b;
            4'h3:    alu_result = alu_a & alu_b;
            4'h4:    alu_result = alu_a | alu_b;
            4'h5:    alu_result = alu_a ^ alu_b;
            4'h6:    alu_result = ~alu_a;
            4'h7:    alu_result = alu_a << 1;
            4'h8:    alu_result = alu_a >> 1;
            4'h9:    alu_result = (alu_a < alu_b) ? 16'd1 : 16'd0;
            4'hA:    alu_result = (alu_a == alu_b) ? 16'd1 : 16'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Register-file port exclusivity is watched on every cycle that uses it.
    always @(negedge clk) begin
        if (rst_n && (ram_read || ram_write))
            checkOutput("one_ram_port", {31'd0, ram_read & ram_write}, 32'd0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic fill_rom_halt();
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hF000;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 64; i++) ram_mem[i] <= '0;
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_r1;
        logic        exp_zf;
        int          exp_cycles;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t vecs [14];

    // One instruction at address 0 with r1=a, r2=b; every other ROM word is HALT.
    task automatic applyStimulus(input vec_t v, output int cycles, output logic [15:0] r1,
                                 output logic zf, output logic [7:0] pc_o, output logic halted_o);
        int first;
        int second;
        fill_rom_halt();
        rom_mem[0] = v.instr;
        clear_ram();
        ram_mem[1] <= v.a;
        ram_mem[2] <= v.b;
        do_reset();
        run    = 1'b1;
        first  = -1;
        second = -1;
        for (int c = 1; c <= 60; c++) begin
            step(1);
            if (rom_read) begin
                if (first < 0)       first  = c;
                else if (second < 0) second = c;
            end
            if (halted) break;
        end
        cycles   = second - first;
        r1       = ram_mem[1];
        zf       = zero_flag;
        pc_o     = pc;
        halted_o = halted;
        run      = 1'b0;
    endtask

    initial begin
        int          cycles;
        logic [15:0] r1;
        logic        zf;
        logic [7:0]  pc_o;
        logic        halted_o;
        int          cnt;

        vecs[0]  = '{16'h2042, 16'd5,     16'd3,     16'd8,     1'b0, 6, 8'h01};
        vecs[1]  = '{16'h3042, 16'd7,     16'd7,     16'd0,     1'b1, 6, 8'h01};
        vecs[2]  = '{16'h4042, 16'h0FF0,  16'h00FF,  16'h00F0,  1'b0, 6, 8'h01};
        vecs[3]  = '{16'h5042, 16'h1200,  16'h0034,  16'h1234,  1'b0, 6, 8'h01};
        vecs[4]  = '{16'h6042, 16'hFFFF,  16'h00FF,  16'hFF00,  1'b0, 6, 8'h01};
        vecs[5]  = '{16'h7042, 16'hFFFF,  16'h1234,  16'h0000,  1'b1, 6, 8'h01};
        vecs[6]  = '{16'h8042, 16'h8001,  16'h0000,  16'h0002,  1'b0, 6, 8'h01};
        vecs[7]  = '{16'h9042, 16'h8001,  16'h0000,  16'h4000,  1'b0, 6, 8'h01};
        vecs[8]  = '{16'hA042, 16'd3,     16'd5,     16'd1,     1'b0, 6, 8'h01};
        vecs[9]  = '{16'hB042, 16'd4,     16'd4,     16'd1,     1'b0, 6, 8'h01};
        vecs[10] = '{16'h1042, 16'hAAAA,  16'h5555,  16'h5555,  1'b0, 5, 8'h01};
        vecs[11] = '{16'hC07F, 16'h9999,  16'h0000,  16'h003F,  1'b0, 3, 8'h01};
        vecs[12] = '{16'h0000, 16'h1111,  16'h2222,  16'h1111,  1'b0, 3, 8'h01};
        vecs[13] = '{16'hD020, 16'h1111,  16'h2222,  16'h1111,  1'b0, 3, 8'h20};

        // Reset values while rst_n is held low.
        run   = 1'b0;
        rst_n = 1'b0;
        step(1);
        checkOutput("rst_pc",        32'(pc),        32'd0);
        checkOutput("rst_zero_flag", 32'(zero_flag), 32'd0);
        checkOutput("rst_halted",    32'(halted),    32'd0);
        checkOutput("rst_rom_read",  32'(rom_read),  32'd0);
        checkOutput("rst_ram_read",  32'(ram_read),  32'd0);
        checkOutput("rst_ram_write", 32'(ram_write), 32'd0);
        checkOutput("rst_alu_op",    32'(alu_op),    32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], cycles, r1, zf, pc_o, halted_o);
            $display("[TB] vector %0d instr %h", i, vecs[i].instr);
            checkOutput("vec_halted", 32'(halted_o), 32'd1);
            checkOutput("vec_cycles", 32'(cycles),   32'(vecs[i].exp_cycles));
            checkOutput("vec_r1",     32'(r1),       32'(vecs[i].exp_r1));
            checkOutput("vec_zf",     32'(zf),       32'(vecs[i].exp_zf));
            checkOutput("vec_pc",     32'(pc_o),     32'(vecs[i].exp_pc));
        end

        // MVI r1,#5; MVI r2,#3; ADD; SUB r1,r1; JZ 0x10 (taken); HALT.
        fill_rom_halt();
        rom_mem[0] = 16'hC045;
        rom_mem[1] = 16'hC083;
        rom_mem[2] = 16'h2042;
        rom_mem[3] = 16'h3041;
        rom_mem[4] = 16'hE010;
        clear_ram();
        do_reset();
        run = 1'b1;
        step(10);
        checkOutput("rdb_alu_op_idle", 32'(alu_op), 32'd0);
        step(1);
        checkOutput("exec_alu_op", 32'(alu_op), 32'd1);
        checkOutput("exec_alu_a",  32'(alu_a),  32'd5);
        checkOutput("exec_alu_b",  32'(alu_b),  32'd3);
        step(1);
        checkOutput("add_wb_write", 32'(ram_write),      32'd1);
        checkOutput("add_wb_addr",  32'(ram_write_addr), 32'd1);
        checkOutput("add_wb_data",  32'(ram_data_in),    32'd8);
        step(1);
        checkOutput("add_r1", 32'(ram_mem[1]), 32'd8);
        checkOutput("add_pc", 32'(pc),         32'd3);
        checkOutput("add_zf", 32'(zero_flag),  32'd0);
        step(9);
        checkOutput("sub_r1",        32'(ram_mem[1]), 32'd0);
        checkOutput("sub_zf",        32'(zero_flag),  32'd1);
        checkOutput("jz_taken_read", 32'(rom_read),   32'd1);
        checkOutput("jz_taken_addr", 32'(rom_addr),   32'h10);
        step(1);
        checkOutput("halt_not_early", 32'(halted), 32'd0);
        step(1);
        checkOutput("halt_cycle3", 32'(halted), 32'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            run = ~run;
            step(1);
            if (rom_read) cnt++;
        end
        checkOutput("halt_no_fetch", 32'(cnt),    32'd0);
        checkOutput("halt_stays",    32'(halted), 32'd1);

        // JZ not taken: SUB r1,r2 gives 2, so the next fetch is at pc+1.
        fill_rom_halt();
        rom_mem[0] = 16'hC045;
        rom_mem[1] = 16'hC083;
        rom_mem[2] = 16'h3042;
        rom_mem[3] = 16'hE010;
        clear_ram();
        do_reset();
        run = 1'b1;
        step(16);
        checkOutput("jz_nt_r1",   32'(ram_mem[1]), 32'd2);
        checkOutput("jz_nt_zf",   32'(zero_flag),  32'd0);
        checkOutput("jz_nt_read", 32'(rom_read),   32'd1);
        checkOutput("jz_nt_addr", 32'(rom_addr),   32'd4);

        // JMP 0xFF then NOP there: pc wraps to 0.
        fill_rom_halt();
        rom_mem[0]   = 16'hD0FF;
        rom_mem[255] = 16'h0000;
        clear_ram();
        do_reset();
        run = 1'b1;
        step(4);
        checkOutput("jmp_ff_addr", 32'(rom_addr), 32'hFF);
        step(3);
        checkOutput("wrap_read", 32'(rom_read), 32'd1);
        checkOutput("wrap_addr", 32'(rom_addr), 32'd0);

        // Reset asserted during the WB of an ADD.
        fill_rom_halt();
        rom_mem[0] = 16'hC045;
        rom_mem[1] = 16'hC083;
        rom_mem[2] = 16'h2042;
        clear_ram();
        do_reset();
        run = 1'b1;
        step(12);
        checkOutput("pre_rst_write", 32'(ram_write), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_wb_write", 32'(ram_write),   32'd0);
        checkOutput("rst_wb_data",  32'(ram_data_in), 32'd0);
        checkOutput("rst_wb_pc",    32'(pc),          32'd0);
        step(1);
        checkOutput("rst_wb_r1",   32'(ram_mem[1]), 32'd5);
        checkOutput("rst_wb_idle", 32'(rom_read),   32'd0);
        rst_n = 1'b1;
        run   = 1'b0;

        // run dropped during RD_A of an ADD; resume after five idle cycles.
        fill_rom_halt();
        rom_mem[0] = 16'hC045;
        rom_mem[1] = 16'hC083;
        rom_mem[2] = 16'h2042;
        rom_mem[3] = 16'hC0C7;
        clear_ram();
        do_reset();
        run = 1'b1;
        step(9);
        checkOutput("rda_read",      32'(ram_read),      32'd1);
        checkOutput("rda_read_addr", 32'(ram_read_addr), 32'd1);
        run = 1'b0;
        step(3);
        checkOutput("drop_wb_write", 32'(ram_write),   32'd1);
        checkOutput("drop_wb_data",  32'(ram_data_in), 32'd8);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (rom_read) cnt++;
        end
        checkOutput("idle_no_fetch", 32'(cnt), 32'd0);
        checkOutput("idle_pc",       32'(pc),  32'd3);
        run = 1'b1;
        step(1);
        checkOutput("resume_read", 32'(rom_read), 32'd1);
        checkOutput("resume_addr", 32'(rom_addr), 32'd3);
        step(2);
        checkOutput("resume_mvi_addr", 32'(ram_write_addr), 32'd3);
        checkOutput("resume_mvi_data", 32'(ram_data_in),    32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
